// File: rtl/updown_round_ctrl.sv
// -----------------------------------------------------------------------------
// updown_round_ctrl
//
// Round controller for the up/down number-guessing game. It draws a secret
// number (1..99) from a free-running 7-bit LFSR when a round starts, and feeds
// it to the guess/compare/display stage. It then consumes that stage's 2-bit
// comparison result, counts attempts, and moves each round through
// IDLE, PLAY, WIN and LOSE.
//
// Parameters
//   MAX_TRIES       attempts allowed per round (1..15)
//   LFSR_SEED       nonzero LFSR reset value
//   TIMEOUT_CYCLES  inactivity limit in PLAY (only with ROUND_TIMEOUT_EN)
//
// Ports
//   clk                in   single clock, rising edge
//   reset              in   asynchronous active-low reset
//   start              in   single-cycle start/restart pulse
//   guess_trigger      in   single-cycle pulse, shared with the guess stage
//   comparison_result  in   2'b00 equal, 2'b01 low, 2'b10 high, 2'b11 reserved
//   actual_number      out  secret number, stable for the whole round
//   tries_used         out  attempts evaluated this round
//   round_state        out  2'b00 IDLE, 2'b01 PLAY, 2'b10 WIN, 2'b11 LOSE
//   guess_enable       out  high only in PLAY
//   win                out  high in WIN
//   lose               out  high in LOSE
//
// Build option
//   ROUND_TIMEOUT_EN   when defined, a PLAY round with no evaluated guess for
//                      TIMEOUT_CYCLES cycles ends in LOSE. When undefined, no
//                      counter is built and PLAY waits indefinitely.
// -----------------------------------------------------------------------------
module updown_round_ctrl #(
  parameter int unsigned MAX_TRIES      = 7,
  parameter logic [6:0]  LFSR_SEED      = 7'h5A,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       guess_trigger,
  input  logic [1:0] comparison_result,
  output logic [6:0] actual_number,
  output logic [3:0] tries_used,
  output logic [1:0] round_state,
  output logic       guess_enable,
  output logic       win,
  output logic       lose
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_LOSE = 2'b11;

  localparam logic [1:0] RES_EQ   = 2'b00;
  localparam logic [1:0] RES_RSVD = 2'b11;

  localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

  // Parameter sanity checks at elaboration time.
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("updown_round_ctrl: MAX_TRIES must be in 1..15");
  end
  if (LFSR_SEED == 7'd0) begin : g_bad_seed
    $error("updown_round_ctrl: LFSR_SEED must be nonzero");
  end
  if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
    $error("updown_round_ctrl: TIMEOUT_CYCLES must be nonzero");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [6:0] lfsr;
  logic [6:0] secret_nxt;
  logic [3:0] tries_nxt;
  logic [3:0] tries_inc;
  logic       eval;
  logic       eval_ok;
  logic       timeout_hit;

  // Values 100..127 fold down by 64 into 36..63; 0 never occurs in the LFSR,
  // so the result is always 1..99.
  function automatic logic [6:0] fold_secret(input logic [6:0] v);
    if (v > 7'd99) begin
      return v - 7'd64;
    end
    return v;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= TRY_LIMIT) begin
      return TRY_LIMIT;
    end
    return v + 4'd1;
  endfunction

  // x^7 + x^6 + 1 Fibonacci LFSR, free-running in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  // The guess stage registers the number on guess_trigger, so its
  // comparison_result is valid one cycle later: align with that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eval <= 1'b0;
    end else begin
      eval <= guess_trigger;
    end
  end

  // An eval only counts while still in PLAY; one arriving after the round has
  // ended is dropped, as is the reserved result code.
  assign eval_ok = eval && (state == ST_PLAY) && (comparison_result != RES_RSVD);

`ifdef ROUND_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  logic [31:0] idle_cnt;

  // Counts cycles spent in PLAY since entry or since the last evaluated guess.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= 32'd0;
    end else if (start || (state != ST_PLAY) || eval_ok) begin
      idle_cnt <= 32'd0;
    end else if (idle_cnt != TIMEOUT_LAST) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_hit = (state == ST_PLAY) && (idle_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic. start overrides everything, including an eval or a
  // timeout landing in the same cycle.
  always_comb begin
    state_nxt  = state;
    tries_nxt  = tries_used;
    secret_nxt = actual_number;
    tries_inc  = sat_inc(tries_used);
    if (start) begin
      state_nxt  = ST_PLAY;
      tries_nxt  = 4'd0;
      secret_nxt = fold_secret(lfsr);
    end else if (state == ST_PLAY) begin
      if (eval_ok) begin
        tries_nxt = tries_inc;
        if (comparison_result == RES_EQ) begin
          state_nxt = ST_WIN;
        end else if (tries_inc == TRY_LIMIT) begin
          state_nxt = ST_LOSE;
        end
      end else if (timeout_hit) begin
        state_nxt = ST_LOSE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      tries_used    <= 4'd0;
      actual_number <= 7'd0;
    end else begin
      state         <= state_nxt;
      tries_used    <= tries_nxt;
      actual_number <= secret_nxt;
    end
  end

  // Outputs decode straight from the state register.
  assign round_state  = state;
  assign guess_enable = (state == ST_PLAY);
  assign win          = (state == ST_WIN);
  assign lose         = (state == ST_LOSE);

endmodule

// File: tb/tb_updown_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_round_ctrl
//
// Directed bench for updown_round_ctrl with MAX_TRIES = 7, LFSR_SEED = 7'h5A
// and TIMEOUT_CYCLES = 10. Inputs change on the falling edge; outputs are
// read on the falling edge, half a cycle after the rising edge that updates
// them. A reference LFSR lets the bench time start pulses to chosen LFSR
// values.
// -----------------------------------------------------------------------------
module tb_updown_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       guess_trigger = 1'b0;
  logic [1:0] comparison_result = 2'b00;
  logic [6:0] actual_number;
  logic [3:0] tries_used;
  logic [1:0] round_state;
  logic       guess_enable;
  logic       win;
  logic       lose;

  logic [6:0] m_lfsr;
  int         n_cmp = 0;
  int         n_bad = 0;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] PLAY = 2'b01;
  localparam logic [1:0] WIN  = 2'b10;
  localparam logic [1:0] LOSE = 2'b11;

  updown_round_ctrl #(
    .MAX_TRIES(7),
    .LFSR_SEED(7'h5A),
    .TIMEOUT_CYCLES(32'd10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .guess_trigger(guess_trigger),
    .comparison_result(comparison_result),
    .actual_number(actual_number),
    .tries_used(tries_used),
    .round_state(round_state),
    .guess_enable(guess_enable),
    .win(win),
    .lose(lose)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^7 + x^6 + 1, seed 7'h5A.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 7'h5A;
    else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Trigger one guess and return after the edge where its evaluation lands.
  task automatic guess(input logic [1:0] res);
    guess_trigger     = 1'b1;
    comparison_result = res;
    tick(1);
    guess_trigger = 1'b0;
    tick(1);
  endtask

  // Wait (bounded) until the LFSR will hold v at the next rising edge.
  task automatic wait_lfsr(input logic [6:0] v, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_lfsr == v) found = 1'b1;
      else tick(1);
    end
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if (round_state !== IDLE) begin n_bad++; $display("FAIL rst_state got %0d want %0d", round_state, IDLE); end
    n_cmp++; if (actual_number !== 7'd0) begin n_bad++; $display("FAIL rst_number got %0d want 0", actual_number); end
    n_cmp++; if (tries_used !== 4'd0) begin n_bad++; $display("FAIL rst_tries got %0d want 0", tries_used); end
    n_cmp++; if ({guess_enable, win, lose} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {guess_enable, win, lose}); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) guess(2'b01);
    tick(1);
    n_cmp++; if (tries_used !== 4'd0) begin n_bad++; $display("FAIL idle_trigger_tries got %0d want 0", tries_used); end
    n_cmp++; if (round_state !== IDLE) begin n_bad++; $display("FAIL idle_trigger_state got %0d want %0d", round_state, IDLE); end
  endtask

  task automatic test_secret();
    bit found;
    wait_lfsr(7'h70, found);
    n_cmp++; if (!found) begin n_bad++; $display("FAIL lfsr_70_wait got timeout want found"); end
    do_start();
    n_cmp++; if (actual_number !== 7'd48) begin n_bad++; $display("FAIL secret_70 got %0d want 48", actual_number); end
    n_cmp++; if (round_state !== PLAY) begin n_bad++; $display("FAIL start_state got %0d want %0d", round_state, PLAY); end
    n_cmp++; if ({guess_enable, win, lose} !== 3'b100) begin n_bad++; $display("FAIL play_flags got %b want 100", {guess_enable, win, lose}); end
    n_cmp++; if (tries_used !== 4'd0) begin n_bad++; $display("FAIL start_tries got %0d want 0", tries_used); end
    // 0x6B = 107 folds to 43; 0x35 = 53 is kept as is.
    wait_lfsr(7'h6B, found);
    do_start();
    n_cmp++; if (actual_number !== 7'd43) begin n_bad++; $display("FAIL secret_6b got %0d want 43", actual_number); end
    wait_lfsr(7'h35, found);
    do_start();
    n_cmp++; if (actual_number !== 7'd53) begin n_bad++; $display("FAIL secret_35 got %0d want 53", actual_number); end
    tick(5);
    n_cmp++; if (actual_number !== 7'd53) begin n_bad++; $display("FAIL secret_hold got %0d want 53", actual_number); end
  endtask

  task automatic test_win();
    logic [1:0] seq [3] = '{2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      guess_trigger     = 1'b1;
      comparison_result = seq[i];
      tick(1);
      guess_trigger = 1'b0;
      n_cmp++; if (tries_used !== 4'(i)) begin n_bad++; $display("FAIL win_early_%0d got %0d want %0d", i, tries_used, i); end
      tick(1);
      n_cmp++; if (tries_used !== 4'(i + 1)) begin n_bad++; $display("FAIL win_tries_%0d got %0d want %0d", i, tries_used, i + 1); end
    end
    n_cmp++; if (round_state !== WIN) begin n_bad++; $display("FAIL win_state got %0d want %0d", round_state, WIN); end
    n_cmp++; if ({guess_enable, win, lose} !== 3'b010) begin n_bad++; $display("FAIL win_flags got %b want 010", {guess_enable, win, lose}); end
    tick(4);
    n_cmp++; if (round_state !== WIN) begin n_bad++; $display("FAIL win_hold got %0d want %0d", round_state, WIN); end
  endtask

  task automatic test_lose();
    do_start();
    guess(2'b11);
    n_cmp++; if (tries_used !== 4'd0) begin n_bad++; $display("FAIL reserved_tries got %0d want 0", tries_used); end
    for (int i = 0; i < 6; i++) guess(2'b01);
    n_cmp++; if (tries_used !== 4'd6 || round_state !== PLAY) begin n_bad++; $display("FAIL six_tries got %0d/%0d want 6/%0d", tries_used, round_state, PLAY); end
    guess(2'b10);
    n_cmp++; if (tries_used !== 4'd7) begin n_bad++; $display("FAIL lose_tries got %0d want 7", tries_used); end
    n_cmp++; if (round_state !== LOSE) begin n_bad++; $display("FAIL lose_state got %0d want %0d", round_state, LOSE); end
    n_cmp++; if ({guess_enable, win, lose} !== 3'b001) begin n_bad++; $display("FAIL lose_flags got %b want 001", {guess_enable, win, lose}); end
    guess(2'b00);
    tick(1);
    n_cmp++; if (tries_used !== 4'd7 || round_state !== LOSE) begin n_bad++; $display("FAIL eighth_trigger got %0d/%0d want 7/%0d", tries_used, round_state, LOSE); end
  endtask

  task automatic test_start_priority();
    do_start();
    guess_trigger     = 1'b1;
    comparison_result = 2'b00;
    tick(1);
    guess_trigger = 1'b0;
    start         = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++; if (round_state !== PLAY || win !== 1'b0) begin n_bad++; $display("FAIL prio_state got %0d want %0d", round_state, PLAY); end
    n_cmp++; if (tries_used !== 4'd0) begin n_bad++; $display("FAIL prio_tries got %0d want 0", tries_used); end
  endtask

  task automatic test_back_to_back();
    guess_trigger     = 1'b1;
    comparison_result = 2'b11;
    tick(1);
    comparison_result = 2'b01;
    tick(1);
    n_cmp++; if (tries_used !== 4'd1 || round_state !== PLAY) begin n_bad++; $display("FAIL b2b_first got %0d/%0d want 1/%0d", tries_used, round_state, PLAY); end
    comparison_result = 2'b00;
    tick(1);
    guess_trigger = 1'b0;
    n_cmp++; if (tries_used !== 4'd2 || round_state !== WIN) begin n_bad++; $display("FAIL b2b_second got %0d/%0d want 2/%0d", tries_used, round_state, WIN); end
    comparison_result = 2'b01;
    tick(1);
    n_cmp++; if (tries_used !== 4'd2 || round_state !== WIN) begin n_bad++; $display("FAIL b2b_after_win got %0d/%0d want 2/%0d", tries_used, round_state, WIN); end
  endtask

  task automatic test_reset_mid_round();
    do_start();
    guess(2'b01);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (round_state !== IDLE || tries_used !== 4'd0 || actual_number !== 7'd0) begin n_bad++; $display("FAIL async_reset got %0d/%0d/%0d want 0/0/0", round_state, tries_used, actual_number); end
    tick(2);
    // Release with start: first edge sees the seed 0x5A = 90.
    reset = 1'b1;
    do_start();
    n_cmp++; if (actual_number !== 7'd90 || round_state !== PLAY) begin n_bad++; $display("FAIL seed_secret got %0d/%0d want 90/%0d", actual_number, round_state, PLAY); end
  endtask

  task automatic test_timeout();
`ifdef ROUND_TIMEOUT_EN
    do_start();
    tick(9);
    n_cmp++; if (round_state !== PLAY) begin n_bad++; $display("FAIL to_before got %0d want %0d", round_state, PLAY); end
    tick(1);
    n_cmp++; if (round_state !== LOSE) begin n_bad++; $display("FAIL to_lose got %0d want %0d", round_state, LOSE); end
    do_start();
    tick(3);
    guess(2'b01);
    tick(9);
    n_cmp++; if (round_state !== PLAY || tries_used !== 4'd1) begin n_bad++; $display("FAIL to_delay_before got %0d/%0d want %0d/1", round_state, tries_used, PLAY); end
    tick(1);
    n_cmp++; if (round_state !== LOSE) begin n_bad++; $display("FAIL to_delay_lose got %0d want %0d", round_state, LOSE); end
`else
    do_start();
    tick(30);
    n_cmp++; if (round_state !== PLAY) begin n_bad++; $display("FAIL no_timeout got %0d want %0d", round_state, PLAY); end
`endif
  endtask

  initial begin
    test_reset();
    test_secret();
    test_win();
    test_lose();
    test_start_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_round();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
